sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Time-multiplexed scan driver for an NDIGITS common-anode seven-segment display. It sits directly downstream of the per-digit decimal extraction and segment-decode chain. It captures the concatenated active-low segment patterns on a load strobe and double-buffers them so updates land only on frame boundaries. It then drives one digit at a time with a refresh prescaler, optional leading-zero blanking and per-slot dead time.

## Interface
Parameters:
- NDIGITS, 4: number of digits scanned; must be 2 to 8.
- PRESCALE, 50000: clock cycles per digit slot; must be at least DEADTIME+2.
- DEADTIME, 2: cycles at the start of each slot with all anodes off (anti-ghosting).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- segs_in  in  7*NDIGITS  active-low patterns, gfedcba per digit; digit k occupies bits 7k+6:7k; digit 0 is least significant.
- load  in  1  single-cycle strobe; captures segs_in.
- blank_lz  in  1  1 = blank leading zero digits.
- segments  out  7  active-low segment drive, gfedcba.
- anodes  out  NDIGITS  active-low digit enables; at most one low.
- frame  out  1  one-cycle pulse when the slot index wraps from NDIGITS-1 to 0.

## Operation
- shadow register: on load, shadow <= segs_in and pending <= 1.
- display register: on a frame wrap with pending=1, display <= shadow and pending <= 0.
- Load in the same cycle as a wrap:
  - shadow takes the new data and pending stays 1.
  - display takes the old shadow contents.
  - The new data transfers at the next wrap.
- Prescale counter cnt counts 0 to PRESCALE-1. At terminal count:
  - cnt <= 0.
  - idx <= idx+1, wrapping NDIGITS-1 to 0.
  - frame <= 1 when idx wraps to 0.
- Leading-zero blanking, with ZERO_PATTERN = 7'b1000000:
  - If blank_lz=1, digit k (k ≥ 1) is blanked when display digit k and every display digit above it equal ZERO_PATTERN.
  - Digit 0 is never blanked.
  - A blanked digit drives segments = 7'h7F; its anode still follows the normal scan.
- Output registers:
  - anodes <= all ones when cnt < DEADTIME; otherwise ~(1 << idx).
  - segments <= the selected display digit, or 7'h7F when blanked.
- blank_lz is sampled live, with no buffering.

## Timing
- Reset values:
  - segments = 7'h7F, anodes = all ones, frame = 0.
  - cnt = 0, idx = 0, pending = 0.
  - shadow and display = all ones (blank).
- Reset is asynchronous and may assert mid-slot or mid-frame; all state returns to the reset values immediately.
- Outputs are registered: segments and anodes reflect cnt and idx from the previous cycle (one cycle latency).
- Load to visible latency: at least one cycle, at most one frame plus one cycle (NDIGITS*PRESCALE+1).
- frame is high for exactly one cycle per NDIGITS*PRESCALE cycles.
- Its first assertion is the cycle after cnt=PRESCALE-1 with idx=NDIGITS-1.
- Back-to-back loads: only the last value before a wrap is transferred. No overflow error exists.
- load held high for multiple cycles: each cycle recaptures segs_in.

## Structure
- Package sevenseg_pkg:
  - localparam ZERO_PATTERN = 7'b1000000.
  - localparam BLANK_PATTERN = 7'h7F.
  - typedef logic [6:0] seg_t.
  - The existing segment decoder imports these same constants.
- Sub-module scan_timer holds:
  - cnt and idx.
  - the terminal-count and frame-pulse logic.
  - outputs idx, in_dead (cnt < DEADTIME) and frame.
- Top level holds shadow, display, pending, the blanking mask and the output registers.
- Counter widths: $clog2(PRESCALE) and $clog2(NDIGITS), each at least 1.

## Test plan
All scenarios use NDIGITS=4, PRESCALE=4, DEADTIME=1.
- Reset release:
  - segments=7F and anodes=F while n_reset=0.
  - After release, anodes cycle through F,E,E,E,F,D,D,D,… (dead-time cycle first in each slot).
  - frame pulses every 16 cycles.
- Load segs for digits 3..0 = 2 (0100100), 0 (1000000), 1 (1111001), 5 (0010010):
  - display is unchanged until the next frame pulse.
  - The following frame shows each pattern in its slot.
- Leading-zero blanking, digits = 0,0,0,7 (7 = 1111000):
  - blank_lz=1: slots 3..1 drive segments=7F and slot 0 drives 1111000.
  - blank_lz=0: slots 3..1 drive 1000000.
  - All zeros with blank_lz=1: only digit 0 shows 1000000.
- Load coincident with wrap:
  - Load A, then load B in the exact wrap cycle.
  - The next frame shows A; the frame after shows B.
- Mid-frame reset:
  - Assert n_reset for 1 cycle at idx=2, cnt=3.
  - Outputs immediately return to 7F/F and the display buffer goes blank.
  - After release, scanning restarts at digit 0.
- Anode exclusivity assertion over 1000 random-load cycles:
  - anodes is all ones or exactly one bit low.
  - frame is never high in consecutive cycles.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment display chain.
// The segment decoder imports the same patterns so blanking agrees with it.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t ZERO_PATTERN  = 7'b1000000;
  localparam seg_t BLANK_PATTERN = 7'h7F;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cwidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_scan_if.sv
// Bus between the segment-decode chain and the scan driver.
// The master side supplies patterns and controls; the slave side drives the display pins.
interface sevenseg_scan_if
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS = 4
);

  logic [7*NDIGITS-1:0] segs_in;
  logic                 load;
  logic                 blank_lz;
  seg_t                 segments;
  logic [NDIGITS-1:0]   anodes;
  logic                 frame;

  modport master (
    output segs_in, load, blank_lz,
    input  segments, anodes, frame
  );

  modport slave (
    input  segs_in, load, blank_lz,
    output segments, anodes, frame
  );

endinterface

// File: rtl/sevenseg_scan_timer.sv
// Refresh prescaler and digit-slot index for the scan driver.
// wrap marks the last cycle of a frame; frame is its registered one-cycle pulse.
module scan_timer
  import sevenseg_pkg::*;
#(
  parameter  int NDIGITS  = 4,
  parameter  int PRESCALE = 50000,
  parameter  int DEADTIME = 2,
  localparam int CW       = cwidth(PRESCALE),
  localparam int IW       = cwidth(NDIGITS)
) (
  input  logic          clock,
  input  logic          n_reset,
  output logic [IW-1:0] idx,
  output logic          in_dead,
  output logic          wrap,
  output logic          frame
);

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);
  localparam logic [CW-1:0] DEAD_N   = CW'(DEADTIME);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc      = (cnt == CNT_LAST);
  assign wrap    = tc && (idx == IDX_LAST);
  assign in_dead = (cnt < DEAD_N);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cnt   <= '0;
      idx   <= '0;
      frame <= 1'b0;
    end else begin
      frame <= wrap;
      if (tc) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment scan driver with double-buffered
// patterns, leading-zero blanking and per-slot anode dead time.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter  int NDIGITS  = 4,
  parameter  int PRESCALE = 50000,
  parameter  int DEADTIME = 2,
  localparam int IW       = cwidth(NDIGITS)
) (
  input  logic           clock,
  input  logic           n_reset,
  sevenseg_scan_if.slave bus
);

  logic [7*NDIGITS-1:0] shadow;
  logic [7*NDIGITS-1:0] display;
  logic                 pending;

  logic [IW-1:0]        idx;
  logic                 in_dead;
  logic                 wrap;
  logic                 frame_w;

  seg_t                 digit [NDIGITS];
  logic [NDIGITS-1:0]   blank_mask;
  logic                 zero_run;

  seg_t                 seg_p0;
  logic [NDIGITS-1:0]   an_p0;

  scan_timer #(
    .NDIGITS  (NDIGITS),
    .PRESCALE (PRESCALE),
    .DEADTIME (DEADTIME)
  ) u_timer (
    .clock   (clock),
    .n_reset (n_reset),
    .idx     (idx),
    .in_dead (in_dead),
    .wrap    (wrap),
    .frame   (frame_w)
  );

  for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
    assign digit[k] = display[7*k +: 7];
  end

  // A load in the wrap cycle still hands the old shadow to the display and
  // keeps pending set, so the new pattern moves across one frame later.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      shadow  <= '1;
      display <= '1;
      pending <= 1'b0;
    end else begin
      if (wrap && pending) begin
        display <= shadow;
      end
      if (bus.load) begin
        shadow  <= bus.segs_in;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // Walk down from the top digit; a digit blanks while every digit at or above it is zero.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int k = NDIGITS - 1; k >= 1; k--) begin
      zero_run      = zero_run && (digit[k] == ZERO_PATTERN);
      blank_mask[k] = bus.blank_lz && zero_run;
    end
  end

  // Output stage: registered from this cycle's slot index and dead-time flag.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      seg_p0 <= BLANK_PATTERN;
      an_p0  <= '1;
    end else begin
      seg_p0 <= blank_mask[idx] ? BLANK_PATTERN : digit[idx];
      an_p0  <= in_dead ? '1 : ~(NDIGITS'(1) << idx);
    end
  end

  assign bus.segments = seg_p0;
  assign bus.anodes   = an_p0;
  assign bus.frame    = frame_w;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: a time-indexed reference model queues the
// expected pins for every clock edge and a negedge monitor compares them.
module tb_sevenseg_scan;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int DT = 1;
  localparam int NP = N * P;
  localparam logic [6:0] ZERO = 7'b1000000;

  typedef struct {
    logic [6:0]   seg;
    logic [N-1:0] an;
    logic         fr;
  } exp_t;

  logic clock   = 1'b0;
  logic n_reset = 1'b0;

  sevenseg_scan_if #(.NDIGITS(N)) bus ();

  sevenseg_scan #(
    .NDIGITS  (N),
    .PRESCALE (P),
    .DEADTIME (DT)
  ) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  exp_t          q [$];
  int            s;
  logic [7*N-1:0] m_shad;
  logic [7*N-1:0] m_disp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic lz_blank(input logic [7*N-1:0] d, input int slot, input logic bl);
    if (!bl || slot == 0) return 1'b0;
    for (int j = slot; j < N; j++)
      if (d[j*7 +: 7] != ZERO) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: s counts clock edges since reset release; the pins after
  // an edge describe slot s/P (mod N) at position s%P, and the display buffer
  // takes the latest loaded pattern at every multiple of N*P edges.
  always @(posedge clock or negedge n_reset) begin
    exp_t e;
    int   slot;
    int   pos;
    if (!n_reset) begin
      s      = 0;
      m_shad = '1;
      m_disp = '1;
      q.delete();
    end else begin
      slot  = (s / P) % N;
      pos   = s % P;
      e.an  = (pos < DT) ? {N{1'b1}} : ~(N'(1) << slot);
      e.seg = lz_blank(m_disp, slot, bus.blank_lz) ? 7'h7F : m_disp[slot*7 +: 7];
      e.fr  = ((s + 1) % NP == 0);
      s++;
      if (s % NP == 0) m_disp = m_shad;
      if (bus.load) m_shad = bus.segs_in;
      q.push_back(e);
    end
  end

  logic prev_fr = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (!n_reset) begin
      check("reset_segments", 32'(bus.segments), 32'h7F);
      check("reset_anodes", 32'(bus.anodes), 32'hF);
      check("reset_frame", 32'(bus.frame), 32'h0);
      prev_fr = 1'b0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      check("segments", 32'(bus.segments), 32'(e.seg));
      check("anodes", 32'(bus.anodes), 32'(e.an));
      check("frame", 32'(bus.frame), 32'(e.fr));
      check("anode_onehot", 32'($countones(~bus.anodes) <= 1), 32'h1);
      check("frame_single", 32'(prev_fr && bus.frame), 32'h0);
      prev_fr = bus.frame;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_load(input logic [7*N-1:0] v);
    bus.segs_in = v;
    bus.load    = 1'b1;
    tick(1);
    bus.load    = 1'b0;
  endtask

  function automatic logic [7*N-1:0] rand_pattern();
    logic [7*N-1:0] v;
    for (int k = 0; k < N; k++)
      v[k*7 +: 7] = ($urandom_range(0, 1) == 0) ? ZERO : 7'($urandom);
    return v;
  endfunction

  initial begin
    logic [7*N-1:0] pat_a;
    logic [7*N-1:0] pat_b;
    int             guard;

    bus.segs_in  = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;

    // Held in reset, then free-running blank scan.
    tick(3);
    n_reset = 1'b1;
    tick(40);

    // Digits 3..0 = 2,0,1,5; visible only from the next frame.
    do_load({7'b0100100, 7'b1000000, 7'b1111001, 7'b0010010});
    tick(40);

    // Leading zeros 0,0,0,7 with and without blanking, then all zeros.
    bus.blank_lz = 1'b1;
    do_load({ZERO, ZERO, ZERO, 7'b1111000});
    tick(40);
    bus.blank_lz = 1'b0;
    tick(20);
    bus.blank_lz = 1'b1;
    do_load({N{ZERO}});
    tick(40);
    bus.blank_lz = 1'b0;

    // Load A, then load B sampled on the exact wrap edge.
    pat_a = {7'b0000000, 7'b0001000, 7'b0000011, 7'b1000110};
    pat_b = {7'b0100001, 7'b0000110, 7'b0001110, 7'b1111001};
    do_load(pat_a);
    guard = 0;
    while (((s + 1) % NP) != 0 && guard < 2 * NP) begin
      tick(1);
      guard++;
    end
    check("wrap_align", 32'(((s + 1) % NP) == 0), 32'h1);
    do_load(pat_b);
    tick(2 * NP + 4);

    // Reset for one cycle at slot 2, position 3.
    guard = 0;
    while ((s % NP) != 11 && guard < 2 * NP) begin
      tick(1);
      guard++;
    end
    check("midreset_align", 32'((s % NP) == 11), 32'h1);
    n_reset = 1'b0;
    #1;
    check("midreset_segments", 32'(bus.segments), 32'h7F);
    check("midreset_anodes", 32'(bus.anodes), 32'hF);
    check("midreset_display", 32'(&dut.display), 32'h1);
    tick(1);
    n_reset = 1'b1;
    tick(2 * NP);

    // Randomized loads and blanking over 1000 cycles.
    for (int i = 0; i < 1000; i++) begin
      bus.load    = ($urandom_range(0, 7) == 0);
      bus.segs_in = rand_pattern();
      if ($urandom_range(0, 31) == 0) bus.blank_lz = ~bus.blank_lz;
      tick(1);
    end
    bus.load = 1'b0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
